// File: rtl/enc_dec_pkg.sv
// Shared encode/decode types: codeword size modes, NOF codes, status codes and size helpers.
package enc_dec_pkg;

  typedef enum logic [1:0] {
    SZ_8  = 2'd0,
    SZ_16 = 2'd1,
    SZ_32 = 2'd2
  } size_e;

  localparam logic [1:0] NOF_NONE   = 2'b00;
  localparam logic [1:0] NOF_SINGLE = 2'b01;
  localparam logic [1:0] NOF_DOUBLE = 2'b10;

  localparam logic [1:0] ST_CLEAN   = 2'b00;
  localparam logic [1:0] ST_CORR    = 2'b01;
  localparam logic [1:0] ST_UNCORR  = 2'b10;

  function automatic logic [31:0] size_mask(input size_e sz);
    case (sz)
      SZ_8:    size_mask = 32'h0000_00FF;
      SZ_16:   size_mask = 32'h0000_FFFF;
      default: size_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [5:0] size_bits(input size_e sz);
    case (sz)
      SZ_8:    size_bits = 6'd8;
      SZ_16:   size_bits = 6'd16;
      default: size_bits = 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready buffer; entry 0 always drives the output so the head is held while stalled.
module skid_buf2 #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          vld0_q, vld0_d;
  logic          vld1_q, vld1_d;
  logic          rdy_q, rdy_d;
  logic [DW-1:0] dat0_q, dat0_d;
  logic [DW-1:0] dat1_q, dat1_d;
  logic          push_c, pop_c;

  assign push_c = in_valid & rdy_q;
  assign pop_c  = vld0_q & out_ready;

  always_comb begin
    vld0_d = vld0_q;
    vld1_d = vld1_q;
    dat0_d = dat0_q;
    dat1_d = dat1_q;
    if (!vld0_q) begin
      if (push_c) begin
        vld0_d = 1'b1;
        dat0_d = in_data;
      end
    end else if (!vld1_q) begin
      if (push_c && pop_c) begin
        dat0_d = in_data;
      end else if (pop_c) begin
        vld0_d = 1'b0;
      end else if (push_c) begin
        vld1_d = 1'b1;
        dat1_d = in_data;
      end
    end else if (pop_c) begin
      // Full: no push possible, the second entry moves to the head.
      dat0_d = dat1_q;
      vld1_d = 1'b0;
    end
    rdy_d = ~(vld0_d & vld1_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
      rdy_q  <= 1'b1;
      dat0_q <= '0;
      dat1_q <= '0;
    end else begin
      vld0_q <= vld0_d;
      vld1_q <= vld1_d;
      rdy_q  <= rdy_d;
      dat0_q <= dat0_d;
      dat1_q <= dat1_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld0_q;
  assign out_data  = dat0_q;

endmodule

// File: rtl/err_fix_stage.sv
// Single-bit error correction stage: flips the flagged bit, masks to the active size,
// buffers the result behind a 2-entry skid buffer and counts corrected/uncorrectable beats.
module err_fix_stage
  import enc_dec_pkg::*;
#(
  parameter int unsigned AMBA_WORD = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AMBA_WORD-1:0] codeword_in,
  input  logic                 Small,
  input  logic                 Medium,
  input  logic [1:0]           NOF,
  input  logic [4:0]           OUT,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AMBA_WORD-1:0] data_out,
  output logic [1:0]           err_status,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] corr_cnt,
  output logic [CNT_WIDTH-1:0] uncorr_cnt
);

  localparam int unsigned PW = AMBA_WORD + 2;

  size_e                size_c;
  logic [5:0]           width_c;
  logic [AMBA_WORD-1:0] flip_c;
  logic [AMBA_WORD-1:0] fixed_c;
  logic [1:0]           status_c;
  logic                 accept_c;
  logic [PW-1:0]        head_c;
  logic [CNT_WIDTH-1:0] corr_q, corr_d;
  logic [CNT_WIDTH-1:0] uncorr_q, uncorr_d;

  assign size_c  = Small ? SZ_8 : (Medium ? SZ_16 : SZ_32);
  assign width_c = size_bits(size_c);

  // OUT=0 means only the overall parity bit was hit, so the data needs no flip.
  always_comb begin
    flip_c   = '0;
    status_c = ST_CLEAN;
    case (NOF)
      NOF_NONE: status_c = ST_CLEAN;
      NOF_SINGLE: begin
        if (OUT == 5'd0) begin
          status_c = ST_CORR;
        end else if ({1'b0, OUT} <= width_c) begin
          flip_c   = AMBA_WORD'(1) << (OUT - 5'd1);
          status_c = ST_CORR;
        end else begin
          status_c = ST_UNCORR;
        end
      end
      NOF_DOUBLE: status_c = ST_UNCORR;
      default:    status_c = ST_UNCORR;
    endcase
    fixed_c = (codeword_in ^ flip_c) & AMBA_WORD'(size_mask(size_c));
  end

  assign accept_c = in_valid & in_ready;

  skid_buf2 #(
    .DW(PW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({status_c, fixed_c}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head_c)
  );

  assign err_status = head_c[PW-1 -: 2];
  assign data_out   = head_c[AMBA_WORD-1:0];

  // Counters bump on accept, saturate at all-ones, and clear wins over increment.
  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (cnt_clr) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else if (accept_c) begin
      if (status_c == ST_CORR && corr_q != {CNT_WIDTH{1'b1}}) begin
        corr_d = corr_q + CNT_WIDTH'(1);
      end
      if (status_c == ST_UNCORR && uncorr_q != {CNT_WIDTH{1'b1}}) begin
        uncorr_d = uncorr_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;

endmodule

// File: tb/tb_err_fix_stage.sv
// Directed bench for err_fix_stage; a second instance with 4-bit counters reaches saturation quickly.
module tb_err_fix_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] codeword_in;
  logic        Small, Medium;
  logic [1:0]  NOF;
  logic [4:0]  OUT;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready, out_valid;
  logic [31:0] data_out;
  logic [1:0]  err_status;
  logic [15:0] corr_cnt, uncorr_cnt;

  logic        sat_in_ready, sat_out_valid;
  logic [31:0] sat_data_out;
  logic [1:0]  sat_err_status;
  logic [3:0]  sat_corr, sat_uncorr;

  int checks = 0;
  int failures = 0;

  err_fix_stage #(.AMBA_WORD(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .codeword_in(codeword_in), .Small(Small), .Medium(Medium), .NOF(NOF), .OUT(OUT),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .err_status(err_status),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  err_fix_stage #(.AMBA_WORD(32), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
    .codeword_in(codeword_in), .Small(Small), .Medium(Medium), .NOF(NOF), .OUT(OUT),
    .out_valid(sat_out_valid), .out_ready(out_ready), .data_out(sat_data_out), .err_status(sat_err_status),
    .cnt_clr(cnt_clr), .corr_cnt(sat_corr), .uncorr_cnt(sat_uncorr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_beat(input logic [31:0] cw, input logic sm, input logic md,
                          input logic [1:0] nof, input logic [4:0] pos);
    codeword_in = cw;
    Small = sm;
    Medium = md;
    NOF = nof;
    OUT = pos;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    set_beat(32'h0, 1'b0, 1'b0, 2'b00, 5'd0);
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", data_out); end
    checks++; if (err_status !== 2'b00) begin failures++; $display("FAIL rst_status got=%b exp=00", err_status); end
    checks++; if (corr_cnt !== 16'h0) begin failures++; $display("FAIL rst_corr got=%h exp=0", corr_cnt); end
    checks++; if (uncorr_cnt !== 16'h0) begin failures++; $display("FAIL rst_uncorr got=%h exp=0", uncorr_cnt); end
  endtask

  task automatic test_single_32();
    set_beat(32'h0000_00F0, 1'b0, 1'b0, 2'b01, 5'd5);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL s32_valid got=%b exp=1", out_valid); end
    checks++; if (data_out !== 32'h0000_00E0) begin failures++; $display("FAIL s32_data got=%h exp=000000e0", data_out); end
    checks++; if (err_status !== 2'b01) begin failures++; $display("FAIL s32_status got=%b exp=01", err_status); end
    checks++; if (corr_cnt !== 16'd1) begin failures++; $display("FAIL s32_corr got=%0d exp=1", corr_cnt); end
    drain();
  endtask

  task automatic test_small();
    set_beat(32'hFFFF_FF5A, 1'b1, 1'b0, 2'b00, 5'd0);
    tick();
    checks++; if (data_out !== 32'h0000_005A) begin failures++; $display("FAIL sm_clean_data got=%h exp=0000005a", data_out); end
    checks++; if (err_status !== 2'b00) begin failures++; $display("FAIL sm_clean_status got=%b exp=00", err_status); end
    set_beat(32'hFFFF_FF5A, 1'b1, 1'b0, 2'b01, 5'd12);
    tick();
    checks++; if (data_out !== 32'h0000_005A) begin failures++; $display("FAIL sm_oor_data got=%h exp=0000005a", data_out); end
    checks++; if (err_status !== 2'b10) begin failures++; $display("FAIL sm_oor_status got=%b exp=10", err_status); end
    checks++; if (uncorr_cnt !== 16'd1) begin failures++; $display("FAIL sm_uncorr got=%0d exp=1", uncorr_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sm_push_pop_ready got=%b exp=1", in_ready); end
    // OUT=9 in 8-bit mode lies just past the word.
    set_beat(32'h0000_0003, 1'b1, 1'b0, 2'b01, 5'd9);
    tick();
    checks++; if (data_out !== 32'h0000_0003) begin failures++; $display("FAIL sm_out9_data got=%h exp=00000003", data_out); end
    checks++; if (err_status !== 2'b10) begin failures++; $display("FAIL sm_out9_status got=%b exp=10", err_status); end
    drain();
  endtask

  task automatic test_medium_and_edges();
    set_beat(32'h1234_8001, 1'b0, 1'b1, 2'b10, 5'd0);
    tick();
    checks++; if (data_out !== 32'h0000_8001) begin failures++; $display("FAIL md_dbl_data got=%h exp=00008001", data_out); end
    checks++; if (err_status !== 2'b10) begin failures++; $display("FAIL md_dbl_status got=%b exp=10", err_status); end
    set_beat(32'h1234_8001, 1'b0, 1'b1, 2'b01, 5'd16);
    tick();
    checks++; if (data_out !== 32'h0000_0001) begin failures++; $display("FAIL md_fix16_data got=%h exp=00000001", data_out); end
    checks++; if (err_status !== 2'b01) begin failures++; $display("FAIL md_fix16_status got=%b exp=01", err_status); end
    set_beat(32'hA5A5_A5A5, 1'b0, 1'b0, 2'b01, 5'd0);
    tick();
    checks++; if (data_out !== 32'hA5A5_A5A5) begin failures++; $display("FAIL par_only_data got=%h exp=a5a5a5a5", data_out); end
    checks++; if (err_status !== 2'b01) begin failures++; $display("FAIL par_only_status got=%b exp=01", err_status); end
    set_beat(32'hDEAD_BEEF, 1'b0, 1'b0, 2'b11, 5'd3);
    tick();
    checks++; if (data_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL nof11_data got=%h exp=deadbeef", data_out); end
    checks++; if (err_status !== 2'b10) begin failures++; $display("FAIL nof11_status got=%b exp=10", err_status); end
    set_beat(32'h0000_1234, 1'b1, 1'b1, 2'b01, 5'd8);
    tick();
    checks++; if (data_out !== 32'h0000_00B4) begin failures++; $display("FAIL both_modes_data got=%h exp=000000b4", data_out); end
    set_beat(32'h0000_0000, 1'b0, 1'b0, 2'b01, 5'd31);
    tick();
    checks++; if (data_out !== 32'h4000_0000) begin failures++; $display("FAIL top_bit_data got=%h exp=40000000", data_out); end
    checks++; if (corr_cnt !== 16'd5) begin failures++; $display("FAIL edges_corr got=%0d exp=5", corr_cnt); end
    checks++; if (uncorr_cnt !== 16'd4) begin failures++; $display("FAIL edges_uncorr got=%0d exp=4", uncorr_cnt); end
    drain();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    set_beat(32'h11, 1'b0, 1'b0, 2'b00, 5'd0);
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
    checks++; if (data_out !== 32'h11) begin failures++; $display("FAIL bp_head1 got=%h exp=11", data_out); end
    set_beat(32'h22, 1'b0, 1'b0, 2'b00, 5'd0);
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", in_ready); end
    checks++; if (data_out !== 32'h11) begin failures++; $display("FAIL bp_hold1 got=%h exp=11", data_out); end
    set_beat(32'h33, 1'b0, 1'b0, 2'b00, 5'd0);
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall got=%b exp=0", in_ready); end
    checks++; if (data_out !== 32'h11 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold2 got=%h/%b exp=11/1", data_out, out_valid); end
    out_ready = 1'b1;
    tick();
    checks++; if (data_out !== 32'h22) begin failures++; $display("FAIL bp_order2 got=%h exp=22", data_out); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_reopen got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (data_out !== 32'h33) begin failures++; $display("FAIL bp_order3 got=%h exp=33", data_out); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    checks++; if (corr_cnt !== 16'd5) begin failures++; $display("FAIL bp_corr got=%0d exp=5", corr_cnt); end
  endtask

  task automatic test_counters();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin failures++; $display("FAIL clr_idle got=%0d/%0d exp=0/0", corr_cnt, uncorr_cnt); end
    for (int i = 0; i < 14; i++) begin
      set_beat(32'h0, 1'b0, 1'b0, 2'b01, 5'd1);
      tick();
    end
    checks++; if (sat_corr !== 4'hE) begin failures++; $display("FAIL sat_preload got=%h exp=e", sat_corr); end
    for (int i = 0; i < 3; i++) begin
      set_beat(32'h0, 1'b0, 1'b0, 2'b01, 5'd1);
      tick();
    end
    checks++; if (sat_corr !== 4'hF) begin failures++; $display("FAIL sat_nowrap got=%h exp=f", sat_corr); end
    checks++; if (corr_cnt !== 16'd17) begin failures++; $display("FAIL cnt16_17 got=%0d exp=17", corr_cnt); end
    cnt_clr = 1'b1;
    set_beat(32'h0, 1'b0, 1'b0, 2'b01, 5'd1);
    tick();
    cnt_clr = 1'b0;
    in_valid = 1'b0;
    checks++; if (corr_cnt !== 16'd0) begin failures++; $display("FAIL clr_prio got=%0d exp=0", corr_cnt); end
    checks++; if (sat_corr !== 4'h0) begin failures++; $display("FAIL sat_clr_prio got=%h exp=0", sat_corr); end
    checks++; if (sat_out_valid !== 1'b1 || sat_data_out !== 32'h1 || sat_err_status !== 2'b01) begin
      failures++; $display("FAIL clr_beat_out got=%b/%h/%b exp=1/00000001/01", sat_out_valid, sat_data_out, sat_err_status);
    end
    checks++; if (sat_in_ready !== 1'b1 || sat_uncorr !== 4'h0) begin failures++; $display("FAIL sat_misc got=%b/%h exp=1/0", sat_in_ready, sat_uncorr); end
    set_beat(32'h0, 1'b0, 1'b0, 2'b01, 5'd1);
    tick();
    in_valid = 1'b0;
    checks++; if (corr_cnt !== 16'd1) begin failures++; $display("FAIL cnt_resume got=%0d exp=1", corr_cnt); end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_beat(32'hAA, 1'b0, 1'b0, 2'b01, 5'd0);
    tick();
    set_beat(32'hBB, 1'b0, 1'b0, 2'b10, 5'd0);
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || corr_cnt !== 16'd2 || uncorr_cnt !== 16'd1) begin
      failures++; $display("FAIL mid_pre got=%b/%0d/%0d exp=0/2/1", in_ready, corr_cnt, uncorr_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_hs got=%b/%b exp=0/1", out_valid, in_ready); end
    checks++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin failures++; $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/0", corr_cnt, uncorr_cnt); end
    checks++; if (data_out !== 32'h0 || err_status !== 2'b00) begin failures++; $display("FAIL mid_rst_data got=%h/%b exp=0/00", data_out, err_status); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale cycle=%0d got=%b exp=0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single_32();
    test_small();
    test_medium_and_edges();
    test_back_pressure();
    test_counters();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
